// File: rtl/proc_ctrl_if.sv
// Control bundle between the instruction source/datapath and the proc_ctrl sequencer.
// The Illegal trap output exists only when PROC_CTRL_ILLEGAL_TRAP_EN is defined.
interface proc_ctrl_if;
  localparam int unsigned WORD_W = 9;
  localparam int unsigned NREG   = 8;

  logic              Run;
  logic [WORD_W-1:0] DIN;
  logic              IRin;
  logic [NREG-1:0]   Rin;
  logic [NREG-1:0]   Rout;
  logic              DINout;
  logic              Gout;
  logic              Ain;
  logic              Gin;
  logic              AddSub;
  logic              Done;
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
  logic              Illegal;
`endif

  // Instruction source / datapath side
  modport master (
    output Run, DIN,
    input  IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
    , input Illegal
`endif
  );

  // Sequencer side
  modport slave (
    input  Run, DIN,
    output IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
    , output Illegal
`endif
  );
endinterface

// File: rtl/proc_ctrl.sv
// Control sequencer for the 9-bit processor: IR plus a T0..T3 step FSM driving register
// load enables and bus selects. Optional sticky illegal-opcode trap: PROC_CTRL_ILLEGAL_TRAP_EN.
module proc_ctrl #(
  parameter logic [8:0] IR_RESET = 9'h000,
  parameter bit         NOP_DONE = 1'b1
) (
  input logic         clk,
  input logic         Reset,
  proc_ctrl_if.slave  ctl
);
  localparam int unsigned WORD_W = 9;
  localparam int unsigned NREG   = 8;

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  state_t              state;
  logic [WORD_W-1:0]   ir;
  logic [2:0]          opcode;
  logic [2:0]          ir_x;
  logic [2:0]          ir_y;
  logic [NREG-1:0]     onehot_x;
  logic [NREG-1:0]     onehot_y;
  logic                run_ok;

  assign opcode   = ir[8:6];
  assign ir_x     = ir[5:3];
  assign ir_y     = ir[2:0];
  assign onehot_x = NREG'(1) << ir_x;
  assign onehot_y = NREG'(1) << ir_y;

`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
  logic illegal;
  assign ctl.Illegal = illegal;
  // A trapped controller refuses new instructions until reset
  assign run_ok = ctl.Run && !illegal;
`else
  assign run_ok = ctl.Run;
`endif

  // State register, instruction register and next-state sequencing
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state <= T0;
      ir    <= IR_RESET;
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
      illegal <= 1'b0;
`endif
    end else begin
      case (state)
        T0: begin
          if (run_ok) begin
            ir    <= ctl.DIN;
            state <= T1;
          end
        end
        T1: begin
          case (opcode)
            3'b000, 3'b001: state <= T0;
            3'b010, 3'b011: state <= T2;
            default: begin
              state <= T0;
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
              illegal <= 1'b1;
`endif
            end
          endcase
        end
        T2:      state <= T3;
        T3:      state <= T0;
        default: state <= T0;
      endcase
    end
  end

  // Output decode from (state, IR, Run); everything forced low while in reset
  always_comb begin
    ctl.IRin   = 1'b0;
    ctl.Rin    = '0;
    ctl.Rout   = '0;
    ctl.DINout = 1'b0;
    ctl.Gout   = 1'b0;
    ctl.Ain    = 1'b0;
    ctl.Gin    = 1'b0;
    ctl.AddSub = 1'b0;
    ctl.Done   = 1'b0;
    if (!Reset) begin
      case (state)
        T0: ctl.IRin = run_ok;
        T1: begin
          case (opcode)
            3'b000: begin
              ctl.Rout = onehot_y;
              ctl.Rin  = onehot_x;
              ctl.Done = 1'b1;
            end
            3'b001: begin
              ctl.DINout = 1'b1;
              ctl.Rin    = onehot_x;
              ctl.Done   = 1'b1;
            end
            3'b010, 3'b011: begin
              ctl.Rout = onehot_x;
              ctl.Ain  = 1'b1;
            end
            default: ctl.Done = 1'(NOP_DONE);
          endcase
        end
        T2: begin
          ctl.Rout   = onehot_y;
          ctl.Gin    = 1'b1;
          ctl.AddSub = ir[6];
        end
        T3: begin
          ctl.Gout = 1'b1;
          ctl.Rin  = onehot_x;
          ctl.Done = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_proc_ctrl.sv
// Directed self-checking bench for proc_ctrl with a small register-file/ALU model on the bus.
module tb_proc_ctrl;
  logic clk;
  logic Reset;
  int   tests;
  int   fails;

  proc_ctrl_if ctl_if ();

  proc_ctrl dut (
    .clk   (clk),
    .Reset (Reset),
    .ctl   (ctl_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] F_DOUT = 6'b100000;
  localparam logic [5:0] F_GOUT = 6'b010000;
  localparam logic [5:0] F_AIN  = 6'b001000;
  localparam logic [5:0] F_GIN  = 6'b000100;
  localparam logic [5:0] F_SUB  = 6'b000010;
  localparam logic [5:0] F_DONE = 6'b000001;
  localparam logic [22:0] ZERO  = 23'h0;

  // Datapath model: R0..R7, A, G and the shared bus
  logic [8:0] rm [8];
  logic [8:0] am;
  logic [8:0] gm;
  logic [8:0] busm;

  always_comb begin
    busm = '0;
    if (ctl_if.DINout) busm = ctl_if.DIN;
    else if (ctl_if.Gout) busm = gm;
    else for (int i = 0; i < 8; i++) if (ctl_if.Rout[i]) busm = rm[i];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) if (ctl_if.Rin[i]) rm[i] <= busm;
    if (ctl_if.Ain) am <= busm;
    if (ctl_if.Gin) gm <= ctl_if.AddSub ? am - busm : am + busm;
  end

  function automatic logic [22:0] outs();
    return {ctl_if.IRin, ctl_if.Rin, ctl_if.Rout, ctl_if.DINout, ctl_if.Gout,
            ctl_if.Ain, ctl_if.Gin, ctl_if.AddSub, ctl_if.Done};
  endfunction

  function automatic logic [22:0] ev(logic irin, logic [7:0] rin, logic [7:0] rout, logic [5:0] f);
    return {irin, rin, rout, f};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [22:0] o;
    Reset = 1'b1;
    ctl_if.Run = 1'b1;
    ctl_if.DIN = 9'h015;
    for (int c = 0; c < 2; c++) begin
      tick();
      o = outs();
      tests++;
      if (o !== ZERO) begin
        $display("FAIL reset_hold[%0d]: got %h want %h", c, o, ZERO);
        fails++;
      end
    end
    ctl_if.Run = 1'b0;
    Reset = 1'b0;
    #1;
    o = outs();
    tests++;
    if (o !== ZERO) begin
      $display("FAIL reset_release: got %h want %h", o, ZERO);
      fails++;
    end
  endtask

  task automatic test_mvi();
    int          xs  [6] = '{1, 3, 4, 0, 7, 5};
    logic [8:0]  ims [6] = '{9'h0AB, 9'h010, 9'h005, 9'h020, 9'h003, 9'h123};
    logic [22:0] o;
    logic [22:0] e;
    for (int k = 0; k < 6; k++) begin
      ctl_if.Run = 1'b1;
      ctl_if.DIN = {3'b001, 3'(xs[k]), 3'b000};
      #1;
      o = outs();
      e = ev(1'b1, 8'h00, 8'h00, 6'b0);
      tests++;
      if (o !== e) begin
        $display("FAIL mvi_t0[%0d]: got %h want %h", k, o, e);
        fails++;
      end
      tick();
      ctl_if.Run = 1'b0;
      ctl_if.DIN = ims[k];
      #1;
      o = outs();
      e = ev(1'b0, 8'(1) << xs[k], 8'h00, F_DOUT | F_DONE);
      tests++;
      if (o !== e) begin
        $display("FAIL mvi_t1[%0d]: got %h want %h", k, o, e);
        fails++;
      end
      tick();
    end
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (rm[xs[k]] !== ims[k]) begin
        $display("FAIL mvi_reg[R%0d]: got %h want %h", xs[k], rm[xs[k]], ims[k]);
        fails++;
      end
    end
  endtask

  task automatic test_mv();
    logic [22:0] o;
    logic [22:0] e;
    ctl_if.Run = 1'b1;
    ctl_if.DIN = 9'h015;
    #1;
    tick();
    ctl_if.Run = 1'b0;
    ctl_if.DIN = 9'h1AA;
    #1;
    o = outs();
    e = ev(1'b0, 8'h04, 8'h20, F_DONE);
    tests++;
    if (o !== e) begin
      $display("FAIL mv_t1: got %h want %h", o, e);
      fails++;
    end
    tick();
    o = outs();
    tests++;
    if (o !== ZERO) begin
      $display("FAIL mv_after: got %h want %h", o, ZERO);
      fails++;
    end
    tests++;
    if (rm[2] !== 9'h123) begin
      $display("FAIL mv_reg: got %h want %h", rm[2], 9'h123);
      fails++;
    end
  endtask

  task automatic test_back_to_back();
    logic [22:0] exp_c [9];
    logic [22:0] o;
    exp_c[0] = ev(1'b1, 8'h00, 8'h00, 6'b0);
    exp_c[1] = ev(1'b0, 8'h00, 8'h08, F_AIN);
    exp_c[2] = ev(1'b0, 8'h00, 8'h10, F_GIN);
    exp_c[3] = ev(1'b0, 8'h08, 8'h00, F_GOUT | F_DONE);
    exp_c[4] = ev(1'b1, 8'h00, 8'h00, 6'b0);
    exp_c[5] = ev(1'b0, 8'h00, 8'h01, F_AIN);
    exp_c[6] = ev(1'b0, 8'h00, 8'h80, F_GIN | F_SUB);
    exp_c[7] = ev(1'b0, 8'h01, 8'h00, F_GOUT | F_DONE);
    exp_c[8] = ZERO;
    for (int c = 0; c < 9; c++) begin
      ctl_if.Run = (c < 7);
      ctl_if.DIN = (c == 0) ? 9'h09C : 9'h0C7;
      #1;
      o = outs();
      tests++;
      if (o !== exp_c[c]) begin
        $display("FAIL b2b_cycle[%0d]: got %h want %h", c, o, exp_c[c]);
        fails++;
      end
      tick();
    end
    tests++;
    if (rm[3] !== 9'h015) begin
      $display("FAIL add_result: got %h want %h", rm[3], 9'h015);
      fails++;
    end
    tests++;
    if (rm[0] !== 9'h01D) begin
      $display("FAIL sub_result: got %h want %h", rm[0], 9'h01D);
      fails++;
    end
  endtask

  task automatic test_idle();
    logic [22:0] o;
    ctl_if.Run = 1'b0;
    for (int c = 0; c < 10; c++) begin
      ctl_if.DIN = c[0] ? 9'h1FF : 9'h015;
      #1;
      o = outs();
      tests++;
      if (o !== ZERO) begin
        $display("FAIL idle[%0d]: got %h want %h", c, o, ZERO);
        fails++;
      end
      tick();
    end
    tests++;
    if (dut.ir !== 9'h0C7) begin
      $display("FAIL idle_ir: got %h want %h", dut.ir, 9'h0C7);
      fails++;
    end
  endtask

  task automatic test_illegal();
    logic [22:0] o;
    logic [22:0] e;
    ctl_if.Run = 1'b1;
    ctl_if.DIN = 9'h1FF;
    #1;
    tick();
    ctl_if.Run = 1'b0;
    #1;
    o = outs();
    e = ev(1'b0, 8'h00, 8'h00, F_DONE);
    tests++;
    if (o !== e) begin
      $display("FAIL illegal_t1: got %h want %h", o, e);
      fails++;
    end
    tick();
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
    ctl_if.Run = 1'b1;
    ctl_if.DIN = 9'h015;
    for (int c = 0; c < 3; c++) begin
      #1;
      o = outs();
      tests++;
      if (o !== ZERO || ctl_if.Illegal !== 1'b1) begin
        $display("FAIL trap_block[%0d]: got %h/%b want %h/1", c, o, ctl_if.Illegal, ZERO);
        fails++;
      end
      tick();
    end
    ctl_if.Run = 1'b0;
    Reset = 1'b1;
    #1;
    tests++;
    if (ctl_if.Illegal !== 1'b0) begin
      $display("FAIL trap_clear: got %b want 0", ctl_if.Illegal);
      fails++;
    end
    Reset = 1'b0;
    tick();
`else
    ctl_if.Run = 1'b1;
    ctl_if.DIN = 9'h015;
    #1;
    o = outs();
    e = ev(1'b1, 8'h00, 8'h00, 6'b0);
    tests++;
    if (o !== e) begin
      $display("FAIL illegal_noblock: got %h want %h", o, e);
      fails++;
    end
    tick();
    ctl_if.Run = 1'b0;
    #1;
    o = outs();
    e = ev(1'b0, 8'h04, 8'h20, F_DONE);
    tests++;
    if (o !== e) begin
      $display("FAIL illegal_next_mv: got %h want %h", o, e);
      fails++;
    end
    tick();
`endif
  endtask

  task automatic test_reset_mid_add();
    logic [22:0] o;
    logic [22:0] e;
    ctl_if.Run = 1'b1;
    ctl_if.DIN = 9'h09C;
    #1;
    tick();
    tick();
    o = outs();
    e = ev(1'b0, 8'h00, 8'h10, F_GIN);
    tests++;
    if (o !== e) begin
      $display("FAIL rst_pre_t2: got %h want %h", o, e);
      fails++;
    end
    Reset = 1'b1;
    #1;
    o = outs();
    tests++;
    if (o !== ZERO) begin
      $display("FAIL rst_async: got %h want %h", o, ZERO);
      fails++;
    end
    tick();
    o = outs();
    tests++;
    if (o !== ZERO) begin
      $display("FAIL rst_held: got %h want %h", o, ZERO);
      fails++;
    end
    Reset = 1'b0;
    #1;
    o = outs();
    e = ev(1'b1, 8'h00, 8'h00, 6'b0);
    tests++;
    if (o !== e) begin
      $display("FAIL rst_restart_t0: got %h want %h", o, e);
      fails++;
    end
    tick();
    ctl_if.Run = 1'b0;
    #1;
    o = outs();
    e = ev(1'b0, 8'h00, 8'h08, F_AIN);
    tests++;
    if (o !== e) begin
      $display("FAIL rst_restart_t1: got %h want %h", o, e);
      fails++;
    end
    tick();
    tick();
    o = outs();
    e = ev(1'b0, 8'h08, 8'h00, F_GOUT | F_DONE);
    tests++;
    if (o !== e) begin
      $display("FAIL rst_restart_t3: got %h want %h", o, e);
      fails++;
    end
    tick();
    tests++;
    if (rm[3] !== 9'h01A) begin
      $display("FAIL rst_add_result: got %h want %h", rm[3], 9'h01A);
      fails++;
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    Reset = 1'b1;
    ctl_if.Run = 1'b0;
    ctl_if.DIN = '0;
    test_reset();
    test_mvi();
    test_mv();
    test_back_to_back();
    test_idle();
    test_illegal();
    test_reset_mid_add();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
